text_renderer_pipe: RTL and testbench

Parametrised, pipelined character-cell text renderer for the VGA path. It maps the timing generator's pixel coordinate (x, y) to a character cell and fetches the character code from the text RAM. It then fetches the glyph row from the font ROM and outputs 8-bit RGB with a per-row foreground palette, a selectable background and a blinking cursor. It sits between the VGA timing generator / keyboard-fed text RAM and the DAC outputs, with RGB registered and a fixed pipeline latency.

---
 rtl/text_render_pkg.sv | 33 +++
 rtl/blink_timer.sv | 36 +++
 rtl/text_renderer_pipe.sv | 167 ++++++++++++++++
 tb/tb_text_renderer_pipe.sv | 235 +++++++++++++++++++++++
 4 files changed

// File: rtl/text_render_pkg.sv
// Shared types and constants for the character-cell text renderer:
// the 24-bit RGB struct, the 16-entry per-row foreground palette and colour helpers.
package text_render_pkg;

    typedef struct packed {
        logic [7:0] r;
        logic [7:0] g;
        logic [7:0] b;
    } rgb_t;

    localparam int PAL_N = 16;

    // Indexed by text row modulo 16; each entry is {r, g, b}.
    localparam logic [23:0] PALETTE [PAL_N] = '{
        24'hFF0000, 24'h0000FF, 24'h00FF00, 24'hFF00FF,
        24'hFFFF00, 24'h00FFFF, 24'hFFFFFF, 24'h78FA1E,
        24'hFA1E78, 24'h1E78FA, 24'h591B2E, 24'h1B2E59,
        24'h2E591B, 24'hC80064, 24'h0064C8, 24'h808080
    };

    function automatic rgb_t palette_rgb(input logic [3:0] idx);
        return rgb_t'(PALETTE[idx]);
    endfunction

    function automatic rgb_t bg_rgb(input logic en_r, input logic en_g, input logic en_b);
        rgb_t c;
        c.r = {8{en_r}};
        c.g = {8{en_g}};
        c.b = {8{en_b}};
        return c;
    endfunction

endpackage

// File: rtl/blink_timer.sv
// Cursor blink timer: counts frame_start pulses and toggles the blink phase
// every BLINK_FRAMES frames, so the phase only ever changes between frames.
module blink_timer #(
    parameter int BLINK_FRAMES = 30
) (
    input  logic clk,
    input  logic rst,
    input  logic i_frame_start,
    output logic o_blink_phase
);

    localparam int CNT_W = (BLINK_FRAMES > 1) ? $clog2(BLINK_FRAMES) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(BLINK_FRAMES - 1);

    logic [CNT_W-1:0] r_cnt;
    logic             r_phase;

    // NOTE: sequential state uses non-blocking assignments so every register
    // samples pre-edge values regardless of statement order.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_cnt   <= '0;
            r_phase <= 1'b1;
        end else if (i_frame_start) begin
            if (r_cnt == CNT_LAST) begin
                r_cnt   <= '0;
                r_phase <= ~r_phase;
            end else begin
                r_cnt <= r_cnt + CNT_W'(1);
            end
        end
    end

    assign o_blink_phase = r_phase;

endmodule

// File: rtl/text_renderer_pipe.sv
// Three-stage character-cell text renderer: pixel -> text RAM address (S0),
// char code -> font ROM address (S1), glyph row -> registered RGB (S2).
module text_renderer_pipe
    import text_render_pkg::*;
#(
    parameter int COLS         = 40,
    parameter int ROWS         = 15,
    parameter int CELL_W       = 16,
    parameter int CELL_H       = 32,
    parameter int X0           = 144,
    parameter int Y0           = 31,
    parameter int CODE_W       = 7,
    parameter int BLINK_FRAMES = 30
) (
    input  logic                                clk,
    input  logic                                rst,
    input  logic [9:0]                          x,
    input  logic [9:0]                          y,
    input  logic                                vidon,
    input  logic                                frame_start,
    output logic [$clog2(COLS*ROWS)-1:0]        char_addr,
    input  logic [CODE_W-1:0]                   char_code,
    output logic [CODE_W+$clog2(CELL_H)-1:0]    glyph_addr,
    input  logic [CELL_W-1:0]                   glyph_row,
    input  logic                                cursor_en,
    input  logic [$clog2(COLS)-1:0]             cursor_col,
    input  logic [$clog2(ROWS)-1:0]             cursor_row,
    input  logic                                cursor_mode,
    input  logic                                bg_r,
    input  logic                                bg_g,
    input  logic                                bg_b,
    output logic [7:0]                          red,
    output logic [7:0]                          green,
    output logic [7:0]                          blue
);

    localparam int CA_W = $clog2(COLS * ROWS);
    localparam int PX_W = $clog2(CELL_W);
    localparam int PY_W = $clog2(CELL_H);
    localparam int CC_W = $clog2(COLS);
    localparam int CR_W = $clog2(ROWS);

    localparam logic [9:0] X_LO = 10'(X0);
    localparam logic [9:0] X_HI = 10'(X0 + COLS * CELL_W);
    localparam logic [9:0] Y_LO = 10'(Y0);
    localparam logic [9:0] Y_HI = 10'(Y0 + ROWS * CELL_H);
    localparam logic [PY_W-1:0] UL_FIRST_ROW = PY_W'(CELL_H - 2);
    localparam logic [PX_W-1:0] PX_MSB       = PX_W'(CELL_W - 1);

    typedef struct packed {
        logic            vidon;
        logic            in_area;
        logic [PX_W-1:0] px;
        logic [PY_W-1:0] py;
        logic [CR_W-1:0] row;
        logic            cur_hit;
    } stage_t;

    // ---------------- S0: cell arithmetic ----------------
    logic            w_in_area;
    logic [9:0]      w_dx;
    logic [9:0]      w_dy;
    logic [CC_W-1:0] w_col;
    logic [CR_W-1:0] w_row;
    logic [PX_W-1:0] w_px;
    logic [PY_W-1:0] w_py;
    logic [CA_W-1:0] w_cell_addr;
    logic            w_cur_rows_ok;
    logic            w_cur_hit;

    assign w_in_area = (x >= X_LO) && (x < X_HI) && (y >= Y_LO) && (y < Y_HI);

    // Outside the area these wrap to junk; in_area masks them downstream.
    assign w_dx  = x - X_LO;
    assign w_dy  = y - Y_LO;
    assign w_col = CC_W'(w_dx >> PX_W);
    assign w_px  = PX_W'(w_dx);
    assign w_row = CR_W'(w_dy >> PY_W);
    assign w_py  = PY_W'(w_dy);

    assign w_cell_addr   = CA_W'(w_row) * CA_W'(COLS) + CA_W'(w_col);
    assign w_cur_rows_ok = !cursor_mode || (w_py >= UL_FIRST_ROW);
    assign w_cur_hit     = cursor_en && (w_col == cursor_col) &&
                           (w_row == cursor_row) && w_cur_rows_ok;

    logic [CA_W-1:0] r_char_addr;
    stage_t          r_s0;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_char_addr <= '0;
            r_s0        <= '0;
        end else begin
            r_char_addr  <= w_in_area ? w_cell_addr : '0;
            r_s0.vidon   <= vidon;
            r_s0.in_area <= w_in_area;
            r_s0.px      <= w_px;
            r_s0.py      <= w_py;
            r_s0.row     <= w_row;
            r_s0.cur_hit <= w_cur_hit;
        end
    end

    assign char_addr = r_char_addr;

    // ---------------- S1: glyph fetch ----------------
    logic [CODE_W+PY_W-1:0] r_glyph_addr;
    stage_t                 r_s1;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_glyph_addr <= '0;
            r_s1         <= '0;
        end else begin
            r_glyph_addr <= {char_code, r_s0.py};
            r_s1         <= r_s0;
        end
    end

    assign glyph_addr = r_glyph_addr;

    // ---------------- S2: pixel colour ----------------
    logic w_blink_phase;

    blink_timer #(
        .BLINK_FRAMES (BLINK_FRAMES)
    ) u_blink_timer (
        .clk           (clk),
        .rst           (rst),
        .i_frame_start (frame_start),
        .o_blink_phase (w_blink_phase)
    );

    logic w_fg_bit;
    logic w_cur;
    logic w_pix;
    rgb_t w_rgb_next;
    rgb_t r_rgb;

    assign w_fg_bit = glyph_row[PX_MSB - r_s1.px];
    assign w_cur    = r_s1.cur_hit && w_blink_phase;
    assign w_pix    = r_s1.in_area && (w_fg_bit ^ w_cur);

    always_comb begin
        w_rgb_next = '0;
        if (r_s1.vidon) begin
            if (w_pix) begin
                w_rgb_next = palette_rgb(4'(r_s1.row));
            end else begin
                w_rgb_next = bg_rgb(bg_r, bg_g, bg_b);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_rgb <= '0;
        end else begin
            r_rgb <= w_rgb_next;
        end
    end

    assign red   = r_rgb.r;
    assign green = r_rgb.g;
    assign blue  = r_rgb.b;

endmodule

// File: tb/tb_text_renderer_pipe.sv
// Directed bench for text_renderer_pipe with behavioural text RAM and font ROM.
module tb_text_renderer_pipe;

    logic        clk = 1'b0;
    logic        rst;
    logic [9:0]  x;
    logic [9:0]  y;
    logic        vidon;
    logic        frame_start;
    logic [9:0]  char_addr;
    logic [6:0]  char_code;
    logic [11:0] glyph_addr;
    logic [15:0] glyph_row;
    logic        cursor_en;
    logic [5:0]  cursor_col;
    logic [3:0]  cursor_row;
    logic        cursor_mode;
    logic        bg_r;
    logic        bg_g;
    logic        bg_b;
    logic [7:0]  red;
    logic [7:0]  green;
    logic [7:0]  blue;

    int n_tests = 0;
    int n_fail  = 0;

    logic [6:0]  text_ram [1024];
    logic [15:0] font_rom [4096];

    assign char_code = text_ram[char_addr];
    assign glyph_row = font_rom[glyph_addr];

    always #5 clk = ~clk;

    text_renderer_pipe dut (
        .clk         (clk),
        .rst         (rst),
        .x           (x),
        .y           (y),
        .vidon       (vidon),
        .frame_start (frame_start),
        .char_addr   (char_addr),
        .char_code   (char_code),
        .glyph_addr  (glyph_addr),
        .glyph_row   (glyph_row),
        .cursor_en   (cursor_en),
        .cursor_col  (cursor_col),
        .cursor_row  (cursor_row),
        .cursor_mode (cursor_mode),
        .bg_r        (bg_r),
        .bg_g        (bg_g),
        .bg_b        (bg_b),
        .red         (red),
        .green       (green),
        .blue        (blue)
    );

    task automatic step(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic check_rgb(input string tag, input logic [23:0] exp);
        check(tag, {8'h00, red, green, blue}, {8'h00, exp});
    endtask

    task automatic pulse_frames(input int n);
        repeat (n) begin
            frame_start = 1'b1;
            step(1);
            frame_start = 1'b0;
            step(1);
        end
    endtask

    task automatic set_pixel(input logic [9:0] px, input logic [9:0] py, input logic von);
        x     = px;
        y     = py;
        vidon = von;
    endtask

    initial begin
        for (int i = 0; i < 1024; i++) text_ram[i] = 7'h00;
        for (int i = 0; i < 4096; i++) font_rom[i] = 16'h0000;
        text_ram[0]   = 7'h41;
        text_ram[42]  = 7'h00;
        text_ram[43]  = 7'h05;
        text_ram[599] = 7'h22;
        font_rom[12'h820] = 16'h8000;   // code 0x41, cell row 0
        font_rom[12'h83F] = 16'hFFFF;   // code 0x41, cell row 31
        font_rom[12'h45F] = 16'h0001;   // code 0x22, cell row 31
        font_rom[12'h0A0] = 16'h8000;   // code 0x05, cell row 0

        rst = 1'b1;
        set_pixel(10'd0, 10'd0, 1'b0);
        frame_start = 1'b0;
        cursor_en   = 1'b0;
        cursor_col  = 6'd0;
        cursor_row  = 4'd0;
        cursor_mode = 1'b0;
        {bg_r, bg_g, bg_b} = 3'b000;

        step(3);
        check_rgb("reset_rgb", 24'h000000);
        check("reset_char_addr", {22'd0, char_addr}, 32'd0);
        check("reset_glyph_addr", {20'd0, glyph_addr}, 32'd0);
        rst = 1'b0;
        step(4);
        check_rgb("idle_rgb", 24'h000000);

        // First text pixel: code 0x41, glyph MSB set, row 0 palette red.
        set_pixel(10'd144, 10'd31, 1'b1);
        step(1);
        check("first_char_addr", {22'd0, char_addr}, 32'd0);
        step(1);
        check("first_glyph_addr", {20'd0, glyph_addr}, 32'h820);
        check_rgb("first_rgb_not_early", 24'h000000);
        step(1);
        check_rgb("first_rgb", 24'hFF0000);

        // Next pixel has a clear glyph bit: white background.
        {bg_r, bg_g, bg_b} = 3'b111;
        set_pixel(10'd145, 10'd31, 1'b1);
        step(3);
        check_rgb("bg_white", 24'hFFFFFF);
        set_pixel(10'd145, 10'd31, 1'b0);
        step(3);
        check_rgb("vidon_off", 24'h000000);

        // Bottom-right text pixel: row 14 palette.
        {bg_r, bg_g, bg_b} = 3'b000;
        set_pixel(10'd783, 10'd510, 1'b1);
        step(1);
        check("last_char_addr", {22'd0, char_addr}, 32'd599);
        step(1);
        check("last_glyph_addr", {20'd0, glyph_addr}, 32'h45F);
        step(1);
        check_rgb("last_rgb_row14", 24'h0064C8);

        // Just past the area edges: background even where the glyph is lit.
        {bg_r, bg_g, bg_b} = 3'b011;
        set_pixel(10'd784, 10'd510, 1'b1);
        step(1);
        check("right_edge_char_addr", {22'd0, char_addr}, 32'd0);
        step(2);
        check_rgb("right_edge_bg", 24'h00FFFF);
        set_pixel(10'd144, 10'd511, 1'b1);
        step(3);
        check_rgb("bottom_edge_bg", 24'h00FFFF);
        set_pixel(10'd143, 10'd62, 1'b1);
        step(3);
        check_rgb("left_edge_bg", 24'h00FFFF);

        // Cursor, invert mode, on a blank cell at col 2 row 1.
        {bg_r, bg_g, bg_b} = 3'b100;
        cursor_en   = 1'b1;
        cursor_col  = 6'd2;
        cursor_row  = 4'd1;
        cursor_mode = 1'b0;
        set_pixel(10'd176, 10'd63, 1'b1);
        step(1);
        check("cursor_char_addr", {22'd0, char_addr}, 32'd42);
        step(2);
        check_rgb("cursor_on", 24'h0000FF);
        pulse_frames(29);
        check_rgb("blink_29_still_on", 24'h0000FF);
        pulse_frames(1);
        check_rgb("blink_30_off", 24'hFF0000);
        pulse_frames(30);
        check_rgb("blink_60_on", 24'h0000FF);

        // Invert mode over a lit glyph bit cancels it; without cursor it shows.
        cursor_col = 6'd3;
        set_pixel(10'd192, 10'd63, 1'b1);
        step(3);
        check_rgb("cursor_xor_lit", 24'hFF0000);
        cursor_en = 1'b0;
        step(3);
        check_rgb("cursor_disabled_lit", 24'h0000FF);

        // Cursor column beyond the screen never matches.
        cursor_en  = 1'b1;
        cursor_col = 6'd45;
        set_pixel(10'd176, 10'd63, 1'b1);
        step(3);
        check_rgb("cursor_col_out_of_range", 24'hFF0000);

        // Underline mode: only the last two cell rows of the cursor cell.
        cursor_col  = 6'd2;
        cursor_mode = 1'b1;
        set_pixel(10'd176, 10'd92, 1'b1);
        step(3);
        check_rgb("underline_row29", 24'hFF0000);
        set_pixel(10'd176, 10'd93, 1'b1);
        step(3);
        check_rgb("underline_row30", 24'h0000FF);
        set_pixel(10'd176, 10'd94, 1'b1);
        step(3);
        check_rgb("underline_row31", 24'h0000FF);

        // Leave blink hidden with a non-zero count, then reset mid-line.
        cursor_mode = 1'b0;
        set_pixel(10'd176, 10'd63, 1'b1);
        pulse_frames(30);
        check_rgb("pre_reset_blink_off", 24'hFF0000);
        pulse_frames(5);
        rst = 1'b1;
        step(1);
        check_rgb("reset_cycle_rgb", 24'h000000);
        rst = 1'b0;
        step(1);
        check_rgb("post_reset_c1", 24'h000000);
        step(1);
        check_rgb("post_reset_c2", 24'h000000);
        step(1);
        check_rgb("post_reset_resume", 24'h0000FF);
        pulse_frames(29);
        check_rgb("post_reset_blink_29", 24'h0000FF);
        pulse_frames(1);
        check_rgb("post_reset_blink_30", 24'hFF0000);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
